axis_dac_spi_tx: RTL and testbench

AXIS_DAC_SPI_TX -- requirements
Module: axis_dac_spi_tx

---
 rtl/axis_dac_spi_tx.sv | 156 +++++++++++++++
 tb/tb_axis_dac_spi_tx.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/axis_dac_spi_tx.sv
// axis_dac_spi_tx
// Two-channel AXI-Stream to SPI DAC transmitter. A round-robin arbiter
// accepts one 12-bit sample from either channel and serialises a 16-bit
// command word (MSB first) on an SPI link with an active-low frame select.
//
// Ports
//   aclk, reset              : clock, asynchronous active-high reset
//   s_axis_chN_tdata/tvalid  : channel N sample (bits [11:0] used)
//   s_axis_chN_tready        : channel N ready (only in IDLE, granted channel)
//   spi_sclk                 : serial clock, idles high
//   spi_mosi                 : serial data, changes when sclk rises
//   spi_sync                 : active-low frame select
//   busy                     : high whenever not IDLE
//   frame_done               : one-cycle pulse on the first GAP cycle
module axis_dac_spi_tx #(
  parameter int CLK_DIV    = 2,
  parameter int GAP_CYCLES = 4
) (
  input  logic        aclk,
  input  logic        reset,
  input  logic [15:0] s_axis_ch0_tdata,
  input  logic        s_axis_ch0_tvalid,
  output logic        s_axis_ch0_tready,
  input  logic [15:0] s_axis_ch1_tdata,
  input  logic        s_axis_ch1_tvalid,
  output logic        s_axis_ch1_tready,
  output logic        spi_sclk,
  output logic        spi_mosi,
  output logic        spi_sync,
  output logic        busy,
  output logic        frame_done
);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);
  localparam logic [4:0] BIT_LAST = 5'd15;

  state_t      state_q;
  logic        sclk_q;
  logic        mosi_q;
  logic        sync_q;
  logic        done_q;
  logic        last_ch_q;   // 1: ch1 was served last
  logic [4:0]  bit_cnt_q;
  logic [7:0]  div_cnt_q;
  logic [7:0]  gap_cnt_q;
  logic [15:0] shreg_q;

  logic        idle_ok;
  logic        grant1;
  logic        grant0;
  logic        accept;
  logic [15:0] word_d;
  logic        bit_end;
  logic        shift_en;
  logic        unused_hi;

  // Upper nibble of each sample is deliberately discarded.
  assign unused_hi = ^{s_axis_ch0_tdata[15:12], s_axis_ch1_tdata[15:12]};

  // Round-robin: ch1 wins if it is the only requester, or both request and
  // ch0 was served last. Reset forces both readies low.
  assign idle_ok  = (state_q == IDLE) && !reset;
  assign grant1   = s_axis_ch1_tvalid && (!s_axis_ch0_tvalid || !last_ch_q);
  assign grant0   = s_axis_ch0_tvalid && !grant1;
  assign s_axis_ch0_tready = idle_ok && grant0;
  assign s_axis_ch1_tready = idle_ok && grant1;
  assign accept   = s_axis_ch0_tready || s_axis_ch1_tready;

  // Command nibble: 0, channel, write-and-update code 01; then 12 data bits.
  assign word_d = {1'b0, grant1, 2'b01,
                   grant1 ? s_axis_ch1_tdata[11:0] : s_axis_ch0_tdata[11:0]};

  // A bit ends at the last cycle of its low sclk phase.
  assign bit_end  = (state_q == SHIFT) && !sclk_q && (div_cnt_q == DIV_LAST);
  assign shift_en = bit_end && (bit_cnt_q != BIT_LAST);

  assign spi_sclk   = sclk_q;
  assign spi_mosi   = mosi_q;
  assign spi_sync   = sync_q;
  assign frame_done = done_q;
  assign busy       = (state_q != IDLE);

  // Shift data path (not reset; only meaningful while SHIFT)
  always_ff @(posedge aclk) begin
    if (accept) begin
      shreg_q <= word_d;
    end else if (shift_en) begin
      shreg_q <= {shreg_q[14:0], 1'b0};
    end
  end

  // Control FSM with registered SPI outputs
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      sclk_q    <= 1'b1;
      mosi_q    <= 1'b0;
      sync_q    <= 1'b1;
      done_q    <= 1'b0;
      last_ch_q <= 1'b1;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (accept) begin
            state_q   <= SHIFT;
            sync_q    <= 1'b0;
            sclk_q    <= 1'b1;
            mosi_q    <= word_d[15];
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
            last_ch_q <= grant1;
          end
        end
        SHIFT: begin
          if (div_cnt_q == DIV_LAST) begin
            div_cnt_q <= '0;
            if (sclk_q) begin
              sclk_q <= 1'b0;
            end else if (bit_cnt_q == BIT_LAST) begin
              state_q   <= GAP;
              sync_q    <= 1'b1;
              sclk_q    <= 1'b1;
              mosi_q    <= 1'b0;
              done_q    <= 1'b1;
              gap_cnt_q <= '0;
            end else begin
              // Next bit: data changes together with the rising sclk edge.
              bit_cnt_q <= bit_cnt_q + 5'd1;
              sclk_q    <= 1'b1;
              mosi_q    <= shreg_q[14];
            end
          end else begin
            div_cnt_q <= div_cnt_q + 8'd1;
          end
        end
        GAP: begin
          done_q <= 1'b0;
          if (gap_cnt_q == GAP_LAST) begin
            state_q <= IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_dac_spi_tx.sv
module tb_axis_dac_spi_tx;

  logic        aclk;
  logic        reset;
  logic [15:0] ch0_data, ch1_data;
  logic        ch0_valid, ch1_valid;
  logic        ch0_ready, ch1_ready;
  logic        spi_sclk, spi_mosi, spi_sync, busy, frame_done;

  int checks = 0;
  int errors = 0;

  axis_dac_spi_tx #(.CLK_DIV(2), .GAP_CYCLES(4)) dut (
    .aclk              (aclk),
    .reset             (reset),
    .s_axis_ch0_tdata  (ch0_data),
    .s_axis_ch0_tvalid (ch0_valid),
    .s_axis_ch0_tready (ch0_ready),
    .s_axis_ch1_tdata  (ch1_data),
    .s_axis_ch1_tvalid (ch1_valid),
    .s_axis_ch1_tready (ch1_ready),
    .spi_sclk          (spi_sclk),
    .spi_mosi          (spi_mosi),
    .spi_sync          (spi_sync),
    .busy              (busy),
    .frame_done        (frame_done)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Monitor state: decoded SPI frames, acceptances, gaps, protocol errors
  int          cyc = 0;
  logic [15:0] words[$];
  int          bits_q[$];
  int          low_q[$];
  int          gaps[$];
  int          acc_cyc[$];
  int          acc_ch[$];
  logic [15:0] sh = '0;
  int          nb = 0;
  int          low_cnt = 0;
  int          gcnt = 0;
  int          done_cnt = 0;
  int          both_rdy_err = 0;
  int          rdy_busy_err = 0;
  logic        prev_sclk = 1'b1;
  logic        prev_sync = 1'b1;

  always @(posedge aclk) cyc <= cyc + 1;

  always @(negedge aclk) begin
    if (!spi_sync) begin
      low_cnt++;
      if (prev_sclk && !spi_sclk) begin
        sh = {sh[14:0], spi_mosi};
        nb++;
      end
    end else if (!prev_sync) begin
      words.push_back(sh);
      bits_q.push_back(nb);
      low_q.push_back(low_cnt);
      sh = '0; nb = 0; low_cnt = 0;
    end
    prev_sclk = spi_sclk;
    prev_sync = spi_sync;
    if (busy && spi_sync) gcnt++;
    else if (gcnt != 0) begin gaps.push_back(gcnt); gcnt = 0; end
    if (frame_done) done_cnt++;
    if (ch0_valid && ch0_ready) begin acc_cyc.push_back(cyc); acc_ch.push_back(0); end
    if (ch1_valid && ch1_ready) begin acc_cyc.push_back(cyc); acc_ch.push_back(1); end
    if (ch0_ready && ch1_ready) both_rdy_err++;
    if (busy && (ch0_ready || ch1_ready)) rdy_busy_err++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic wait_acc(input int n);
    for (int i = 0; i < 1000 && acc_cyc.size() < n; i++) @(posedge aclk);
    #1;
    chk("acc_wait", (acc_cyc.size() >= n), 1);
  endtask

  task automatic wait_words(input int n);
    for (int i = 0; i < 2000 && words.size() < n; i++) @(posedge aclk);
    repeat (8) @(posedge aclk);
    #1;
    chk("frame_wait", (words.size() >= n), 1);
  endtask

  int b, bw, bg, d0;

  initial begin
    reset = 1'b1;
    ch0_data = '0; ch1_data = '0; ch0_valid = 1'b0; ch1_valid = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_sync", spi_sync, 1);
    chk("rst_sclk", spi_sclk, 1);
    chk("rst_mosi", spi_mosi, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    ch0_valid = 1'b1; ch1_valid = 1'b1;
    #1;
    chk("rst_rdy0", ch0_ready, 0);
    chk("rst_rdy1", ch1_ready, 0);
    ch0_valid = 1'b0; ch1_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    // ch0 0x0ABC -> 0x1ABC
    b = acc_cyc.size(); bw = words.size(); d0 = done_cnt;
    ch0_data = 16'h0ABC; ch0_valid = 1'b1;
    wait_acc(b + 1);
    ch0_valid = 1'b0;
    wait_words(bw + 1);
    chk("w_abc", words[bw], 16'h1ABC);
    chk("bits_abc", bits_q[bw], 16);
    chk("low_abc", low_q[bw], 64);
    chk("done_abc", done_cnt, d0 + 1);

    // ch1 0xF123 -> 0x5123 (upper nibble masked)
    b = acc_cyc.size(); bw = words.size(); d0 = done_cnt;
    ch1_data = 16'hF123; ch1_valid = 1'b1;
    wait_acc(b + 1);
    ch1_valid = 1'b0;
    wait_words(bw + 1);
    chk("w_123", words[bw], 16'h5123);
    chk("bits_123", bits_q[bw], 16);
    chk("done_123", done_cnt, d0 + 1);

    // Both valid after reset: ch0, ch1, ch0
    reset = 1'b1;
    tick();
    reset = 1'b0;
    b = acc_cyc.size(); bw = words.size(); bg = gaps.size();
    ch0_data = 16'h0111; ch1_data = 16'h0222;
    ch0_valid = 1'b1; ch1_valid = 1'b1;
    wait_acc(b + 3);
    ch0_valid = 1'b0; ch1_valid = 1'b0;
    wait_words(bw + 3);
    chk("rr_ch0", acc_ch[b], 0);
    chk("rr_ch1", acc_ch[b+1], 1);
    chk("rr_ch2", acc_ch[b+2], 0);
    chk("rr_w0", words[bw], 16'h1111);
    chk("rr_w1", words[bw+1], 16'h5222);
    chk("rr_w2", words[bw+2], 16'h1111);
    chk("rr_per", acc_cyc[b+1] - acc_cyc[b], 69);

    // ch0 held: back-to-back period and gap length
    b = acc_cyc.size(); bw = words.size(); bg = gaps.size();
    ch0_data = 16'h0FFF; ch0_valid = 1'b1;
    wait_acc(b + 3);
    ch0_valid = 1'b0;
    wait_words(bw + 3);
    chk("b2b_per1", acc_cyc[b+1] - acc_cyc[b], 69);
    chk("b2b_per2", acc_cyc[b+2] - acc_cyc[b+1], 69);
    chk("b2b_gap", gaps[bg], 4);
    chk("b2b_w", words[bw+1], 16'h1FFF);

    // Reset mid-frame at bit 7
    b = acc_cyc.size(); bw = words.size(); d0 = done_cnt;
    ch0_data = 16'h0555; ch0_valid = 1'b1;
    wait_acc(b + 1);
    ch0_valid = 1'b0;
    for (int i = 0; i < 200 && nb < 7; i++) @(negedge aclk);
    @(posedge aclk);
    #1;
    reset = 1'b1;
    #1;
    chk("abort_sync", spi_sync, 1);
    chk("abort_sclk", spi_sclk, 1);
    chk("abort_busy", busy, 0);
    tick();
    tick();
    reset = 1'b0;
    repeat (10) tick();
    chk("abort_bits", bits_q[bw], 7);
    chk("abort_done", done_cnt, d0);
    ch1_data = 16'h0999; ch1_valid = 1'b1;
    wait_acc(b + 2);
    ch1_valid = 1'b0;
    wait_words(bw + 2);
    chk("post_w", words[bw+1], 16'h5999);
    chk("post_bits", bits_q[bw+1], 16);
    chk("post_low", low_q[bw+1], 64);
    chk("post_done", done_cnt, d0 + 1);

    // tvalid raised during SHIFT: captured once, at first IDLE cycle
    b = acc_cyc.size(); bw = words.size();
    ch0_data = 16'h0123; ch0_valid = 1'b1;
    wait_acc(b + 1);
    ch0_valid = 1'b0;
    ch1_data = 16'h0456; ch1_valid = 1'b1;
    wait_acc(b + 2);
    ch1_valid = 1'b0;
    wait_words(bw + 2);
    repeat (20) tick();
    chk("late_cnt", acc_cyc.size(), b + 2);
    chk("late_ch", acc_ch[b+1], 1);
    chk("late_per", acc_cyc[b+1] - acc_cyc[b], 69);
    chk("late_w0", words[bw], 16'h1123);
    chk("late_w1", words[bw+1], 16'h5456);

    chk("both_ready", both_rdy_err, 0);
    chk("ready_busy", rdy_busy_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
